// File: rtl/fwrisc_exec_pkg.sv
// fwrisc_exec_pkg: op encodings, FSM state type, reset PC and load/store lane helpers
package fwrisc_exec_pkg;
  localparam logic [4:0] OP_TYPE_ARITH = 5'd0;
  localparam logic [4:0] OP_TYPE_BRANCH = 5'd1;
  localparam logic [4:0] OP_TYPE_LDST = 5'd2;
  localparam logic [4:0] OP_TYPE_JUMP = 5'd3;
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4;
  localparam logic [5:0] ALU_SLT = 6'd5;
  localparam logic [5:0] ALU_SLTU = 6'd6;
  localparam logic [5:0] ALU_SLL = 6'd7;
  localparam logic [5:0] ALU_SRL = 6'd8;
  localparam logic [5:0] ALU_SRA = 6'd9;
  localparam logic [5:0] BR_EQ = 6'd0;
  localparam logic [5:0] BR_NE = 6'd1;
  localparam logic [5:0] BR_LT = 6'd2;
  localparam logic [5:0] BR_GE = 6'd3;
  localparam logic [5:0] BR_LTU = 6'd4;
  localparam logic [5:0] BR_GEU = 6'd5;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [5:0] LDST_LB = 6'h00;
  localparam logic [5:0] LDST_LH = 6'h01;
  localparam logic [5:0] LDST_LW = 6'h02;
  localparam logic [5:0] LDST_LBU = 6'h04;
  localparam logic [5:0] LDST_LHU = 6'h05;
  localparam logic [5:0] LDST_SB = 6'h08;
  localparam logic [5:0] LDST_SH = 6'h09;
  localparam logic [5:0] LDST_SW = 6'h0A;
  localparam logic [30:0] RESET_PC = 31'h4000_0000;
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, MEM} exec_state_e;
  function automatic logic ldst_misaligned(logic [1:0] sz, logic [1:0] ad);
    return sz == SZ_B ? 1'b0 : sz == SZ_H ? ad[0] : ad != 2'd0;
  endfunction
  function automatic logic [3:0] ldst_strobe(logic [1:0] sz, logic [1:0] ad);
    return sz == SZ_B ? 4'b0001 << ad : sz == SZ_H ? 4'b0011 << ad : 4'b1111;
  endfunction
  function automatic logic [31:0] ldst_wdata(logic [1:0] sz, logic [31:0] d);
    return sz == SZ_B ? {4{d[7:0]}} : sz == SZ_H ? {2{d[15:0]}} : d;
  endfunction
  function automatic logic [31:0] ldst_load(logic [31:0] d, logic [1:0] sz, logic uns, logic [1:0] ad);
    logic [31:0] l;
    l = d >> {ad, 3'b000};
    return sz == SZ_B ? {{24{l[7] & ~uns}}, l[7:0]} : sz == SZ_H ? {{16{l[15] & ~uns}}, l[15:0]} : l;
  endfunction
endpackage

// File: rtl/fwrisc_alu.sv
// fwrisc_alu: combinational arithmetic/logic result and branch compare
module fwrisc_alu
  import fwrisc_exec_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        taken
);
  logic lt, ltu;
  always_comb begin
    lt = $signed(a) < $signed(b);
    ltu = a < b;
    result = op == ALU_ADD ? a + b :
             op == ALU_SUB ? a - b :
             op == ALU_AND ? a & b :
             op == ALU_OR ? a | b :
             op == ALU_XOR ? a ^ b :
             op == ALU_SLT ? {31'd0, lt} :
             op == ALU_SLTU ? {31'd0, ltu} : 32'd0;
    taken = op == BR_EQ ? a == b :
            op == BR_NE ? a != b :
            op == BR_LT ? lt :
            op == BR_GE ? !lt :
            op == BR_LTU ? ltu :
            op == BR_GEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/fwrisc_exec_stage.sv
// fwrisc_exec_stage: execute stage with one-cycle ALU/branch/jump, bit-serial shifts and a load/store port
module fwrisc_exec_stage
  import fwrisc_exec_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        decode_valid,
  input  logic        instr_c,
  input  logic [4:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [5:0]  op,
  input  logic [31:0] op_c,
  input  logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  output logic        instr_complete,
  output logic [30:0] pc,
  output logic        pc_seq,
  output logic [31:0] daddr,
  output logic        dvalid,
  output logic        dwrite,
  output logic [31:0] dwdata,
  output logic [3:0]  dwstb,
  input  logic [31:0] drdata,
  input  logic        dready
);
  exec_state_e state, state_n;
  logic [4:0] r_type, sh_cnt;
  logic [5:0] r_op, r_rd;
  logic [31:0] r_a, r_b, r_c, sh_val, sh_next, alu_res, ea, wdata;
  logic [30:0] pc_inc, tgt;
  logic r_c16, taken, is_shift, misal, retire, wr, seq;
  fwrisc_alu u_alu (.op(r_op), .a(r_a), .b(r_b), .result(alu_res), .taken(taken));
  assign pc_inc = pc + (r_c16 ? 31'd1 : 31'd2);
  assign ea = r_a + r_c;
  assign is_shift = r_op == ALU_SLL || r_op == ALU_SRL || r_op == ALU_SRA;
  assign sh_next = r_op == ALU_SLL ? sh_val << 1 : r_op == ALU_SRA ? {sh_val[31], sh_val[31:1]} : sh_val >> 1;
  assign misal = ldst_misaligned(r_op[1:0], ea[1:0]);
  always_comb begin
    state_n = state;
    retire = 1'b0;
    wr = 1'b0;
    wdata = rd_wdata;
    tgt = pc_inc;
    seq = 1'b1;
    case (state)
      IDLE: state_n = decode_valid && !instr_complete ? EXEC : IDLE;
      EXEC: begin
        case (r_type)
          OP_TYPE_ARITH: begin
            retire = !is_shift || r_b[4:0] == 5'd0;
            wr = 1'b1;
            wdata = is_shift ? r_a : alu_res;
            state_n = SHIFT;
          end
          OP_TYPE_BRANCH: begin
            retire = 1'b1;
            tgt = taken ? pc + r_c[31:1] : pc_inc;
            seq = !taken;
          end
          OP_TYPE_JUMP: begin
            retire = 1'b1;
            wr = 1'b1;
            wdata = {pc_inc, 1'b0};
            tgt = ea[31:1];
            seq = 1'b0;
          end
          OP_TYPE_LDST: begin
            retire = misal;
            state_n = MEM;
          end
          default: retire = 1'b1;
        endcase
      end
      SHIFT: begin
        retire = sh_cnt == 5'd1;
        wr = 1'b1;
        wdata = sh_next;
      end
      MEM: begin
        retire = dready;
        wr = !r_op[3];
        wdata = ldst_load(drdata, r_op[1:0], r_op[2], ea[1:0]);
      end
      default: state_n = IDLE;
    endcase
    if (retire) state_n = IDLE;
  end
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      r_type <= op_type;
      r_op <= op;
      r_a <= op_a;
      r_b <= op_b;
      r_c <= op_c;
      r_rd <= rd_waddr;
      r_c16 <= instr_c;
    end
    if (state == EXEC) begin
      sh_val <= r_a;
      sh_cnt <= r_b[4:0];
    end else if (state == SHIFT) begin
      sh_val <= sh_next;
      sh_cnt <= sh_cnt - 5'd1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      pc_seq <= 1'b0;
      rd_wdata <= 32'd0;
      rd_wen <= 1'b0;
      instr_complete <= 1'b0;
      daddr <= 32'd0;
      dvalid <= 1'b0;
      dwrite <= 1'b0;
      dwdata <= 32'd0;
      dwstb <= 4'd0;
    end else begin
      state <= state_n;
      instr_complete <= retire;
      rd_wen <= retire && wr && r_rd != 6'd0;
      if (retire) pc <= tgt;
      if (retire) pc_seq <= seq;
      if (retire && wr) rd_wdata <= wdata;
      dvalid <= state_n == MEM;
      dwrite <= state_n == MEM && r_op[3];
      dwstb <= state_n == MEM && r_op[3] ? ldst_strobe(r_op[1:0], ea[1:0]) : 4'd0;
      if (state == EXEC && state_n == MEM) begin
        daddr <= {ea[31:2], 2'b00};
        dwdata <= ldst_wdata(r_op[1:0], r_b);
      end
    end
  end
endmodule

// File: tb/tb_fwrisc_exec_stage.sv
// tb_fwrisc_exec_stage: table-driven scoreboard bench for the execute stage
module tb_fwrisc_exec_stage;
  import fwrisc_exec_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic decode_valid = 1'b0;
  logic instr_c = 1'b0;
  logic dready = 1'b0;
  logic [4:0] op_type = 5'd0;
  logic [5:0] op = 6'd0;
  logic [5:0] rd_waddr = 6'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] op_c = 32'd0;
  logic [31:0] drdata = 32'd0;
  logic [31:0] rd_wdata, daddr, dwdata;
  logic rd_wen, instr_complete, pc_seq, dvalid, dwrite;
  logic [30:0] pc;
  logic [3:0] dwstb;
  int total = 0;
  int bad = 0;
  int cur = -1;
  always #5 clock = ~clock;
  fwrisc_exec_stage dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .instr_c(instr_c),
    .op_type(op_type), .op_a(op_a), .op_b(op_b), .op(op), .op_c(op_c), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .instr_complete(instr_complete), .pc(pc), .pc_seq(pc_seq),
    .daddr(daddr), .dvalid(dvalid), .dwrite(dwrite), .dwdata(dwdata), .dwstb(dwstb),
    .drdata(drdata), .dready(dready)
  );
  typedef struct packed {
    logic [4:0] typ;
    logic [5:0] op;
    logic [31:0] a, b, c;
    logic [5:0] rd;
    logic c16;
    logic [31:0] wd;
    logic wd_rel, wen;
    logic [31:0] pcv;
    logic pc_abs, seq;
    int lat, dv;
    logic [31:0] rdata, daddr;
    logic [3:0] stb;
    logic [31:0] dwd;
    logic dwr;
    logic [1:0] quirk;
  } vec_t;
  typedef struct packed {
    logic wen;
    logic [31:0] wdata, pc;
    logic seq;
  } exp_t;
  exp_t sbq[$];
  vec_t tab[$];
  logic [31:0] m_pc;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", n, cur, act, exp);
    end
  endtask
  function automatic vec_t al(logic [5:0] o, logic [31:0] a, logic [31:0] b, logic [5:0] rd, logic c16, logic [31:0] wd, int lat, logic [1:0] q);
    vec_t v = '0;
    v.typ = OP_TYPE_ARITH; v.op = o; v.a = a; v.b = b; v.rd = rd; v.c16 = c16;
    v.wd = wd; v.wen = rd != 6'd0; v.pcv = c16 ? 32'd2 : 32'd4; v.seq = 1'b1; v.lat = lat; v.quirk = q;
    return v;
  endfunction
  function automatic vec_t br(logic [5:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] c, logic c16, logic tk);
    vec_t v = '0;
    v.typ = OP_TYPE_BRANCH; v.op = o; v.a = a; v.b = b; v.c = c; v.rd = 6'd3; v.c16 = c16;
    v.pcv = tk ? c : c16 ? 32'd2 : 32'd4; v.seq = !tk; v.lat = 2;
    return v;
  endfunction
  function automatic vec_t jp(logic [31:0] a, logic [31:0] c, logic [5:0] rd, logic c16, logic [31:0] t);
    vec_t v = '0;
    v.typ = OP_TYPE_JUMP; v.a = a; v.c = c; v.rd = rd; v.c16 = c16;
    v.wd = c16 ? 32'd2 : 32'd4; v.wd_rel = 1'b1; v.wen = rd != 6'd0; v.pcv = t; v.pc_abs = 1'b1; v.lat = 2;
    return v;
  endfunction
  function automatic vec_t ls(logic [5:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] c, logic [5:0] rd, logic [31:0] rdata, int rdy,
                              logic [31:0] wd, logic wen, logic [31:0] da, logic [3:0] stb, logic [31:0] dwd);
    vec_t v = '0;
    v.typ = OP_TYPE_LDST; v.op = o; v.a = a; v.b = b; v.c = c; v.rd = rd; v.rdata = rdata;
    v.wd = wd; v.wen = wen; v.pcv = 32'd4; v.seq = 1'b1; v.dv = rdy; v.lat = 2 + rdy;
    v.daddr = da; v.stb = stb; v.dwd = dwd; v.dwr = o[3];
    return v;
  endfunction
  task automatic issue(input vec_t v);
    exp_t e;
    int lat, dv;
    logic [31:0] ad, dw;
    logic [3:0] sb;
    logic w;
    @(negedge clock);
    op_type = v.typ; op = v.op; op_a = v.a; op_b = v.b; op_c = v.c; rd_waddr = v.rd; instr_c = v.c16;
    drdata = v.rdata; dready = v.quirk[1]; decode_valid = 1'b1;
    e.wen = v.wen;
    e.wdata = v.wd_rel ? m_pc + v.wd : v.wd;
    e.pc = v.pc_abs ? v.pcv : m_pc + v.pcv;
    e.seq = v.seq;
    sbq.push_back(e);
    m_pc = e.pc;
    lat = 0; dv = 0; ad = 0; dw = 0; sb = 0; w = 0;
    while (lat < 200) begin
      @(negedge clock);
      lat++;
      if (v.quirk[0]) decode_valid = 1'b0;
      if (dvalid) begin
        dv++; ad = daddr; dw = dwdata; sb = dwstb; w = dwrite;
      end
      dready = dvalid ? dv == v.dv : v.quirk[1];
      if (instr_complete) break;
    end
    decode_valid = 1'b0;
    dready = 1'b0;
    chk("latency", lat, v.lat);
    chk("dvalid_cycles", dv, v.dv);
    if (dv != 0) begin
      chk("daddr", ad, v.daddr);
      chk("dwrite", 32'(w), 32'(v.dwr));
    end
    if (v.dwr && v.dv != 0) begin
      chk("dwstb", 32'(sb), 32'(v.stb));
      chk("dwdata", dw, v.dwd);
    end
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (!reset && instr_complete) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_complete row=%0d got=1 want=0", cur);
      end else begin
        e = sbq.pop_front();
        chk("rd_wen", 32'(rd_wen), 32'(e.wen));
        if (e.wen) chk("rd_wdata", rd_wdata, e.wdata);
        chk("pc", {pc, 1'b0}, e.pc);
        chk("pc_seq", 32'(pc_seq), 32'(e.seq));
      end
    end
    if (!reset && rd_wen && !instr_complete) begin
      total++; bad++;
      $display("FAIL stray_rd_wen row=%0d got=1 want=0", cur);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog row=%0d got=timeout want=finish", cur);
    $fatal(1);
  end
  initial begin
    int n;
    tab.push_back(al(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 6'd5, 1'b0, 32'h0, 2, 2'b10));
    tab.push_back(al(ALU_SUB, 32'd5, 32'd7, 6'd1, 1'b0, 32'hFFFF_FFFE, 2, 2'b00));
    tab.push_back(al(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 6'd2, 1'b0, 32'hF000_F000, 2, 2'b00));
    tab.push_back(al(ALU_OR, 32'h0000_0F00, 32'h0000_00F0, 6'd2, 1'b0, 32'h0000_0FF0, 2, 2'b00));
    tab.push_back(al(ALU_XOR, 32'hFFFF_0000, 32'h0FF0_0FF0, 6'd2, 1'b0, 32'hF00F_0FF0, 2, 2'b00));
    tab.push_back(al(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 6'd6, 1'b0, 32'd1, 2, 2'b00));
    tab.push_back(al(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 6'd6, 1'b0, 32'd0, 2, 2'b00));
    tab.push_back(al(ALU_ADD, 32'd1, 32'd2, 6'd0, 1'b1, 32'd3, 2, 2'b00));
    tab.push_back(al(ALU_SLL, 32'd1, 32'd31, 6'd8, 1'b0, 32'h8000_0000, 33, 2'b00));
    tab.push_back(al(ALU_SRL, 32'h8000_0000, 32'd4, 6'd8, 1'b0, 32'h0800_0000, 6, 2'b01));
    tab.push_back(al(ALU_SRA, 32'h8000_0000, 32'd4, 6'd8, 1'b0, 32'hF800_0000, 6, 2'b00));
    tab.push_back(al(ALU_SRA, 32'h8000_0000, 32'd0, 6'd8, 1'b0, 32'h8000_0000, 2, 2'b00));
    tab.push_back(jp(32'h8000_0010, 32'd0, 6'd1, 1'b0, 32'h8000_0010));
    tab.push_back(br(BR_EQ, 32'd7, 32'd7, 32'hFFFF_FFF8, 1'b0, 1'b1));
    tab.push_back(br(BR_NE, 32'd7, 32'd7, 32'd16, 1'b0, 1'b0));
    tab.push_back(br(BR_LT, 32'hFFFF_FFFE, 32'd1, 32'd16, 1'b0, 1'b1));
    tab.push_back(br(BR_GE, 32'hFFFF_FFFE, 32'd1, 32'd16, 1'b1, 1'b0));
    tab.push_back(br(BR_LTU, 32'hFFFF_FFFE, 32'd1, 32'd16, 1'b0, 1'b0));
    tab.push_back(br(BR_GEU, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFC, 1'b0, 1'b1));
    tab.push_back(jp(32'h8000_1001, 32'd2, 6'd9, 1'b1, 32'h8000_1002));
    tab.push_back(ls(LDST_LB, 32'h1000, 32'd0, 32'd3, 6'd7, 32'h8000_0000, 3, 32'hFFFF_FF80, 1'b1, 32'h1000, 4'd0, 32'd0));
    tab.push_back(ls(LDST_LBU, 32'h1000, 32'd0, 32'd3, 6'd7, 32'h8000_0000, 2, 32'h0000_0080, 1'b1, 32'h1000, 4'd0, 32'd0));
    tab.push_back(ls(LDST_LH, 32'h1002, 32'd0, 32'd0, 6'd7, 32'h8001_0000, 1, 32'hFFFF_8001, 1'b1, 32'h1000, 4'd0, 32'd0));
    tab.push_back(ls(LDST_LHU, 32'h1000, 32'd0, 32'd2, 6'd7, 32'h8001_0000, 1, 32'h0000_8001, 1'b1, 32'h1000, 4'd0, 32'd0));
    tab.push_back(ls(LDST_LW, 32'h1000, 32'd0, 32'd4, 6'd7, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b1, 32'h1004, 4'd0, 32'd0));
    tab.push_back(ls(LDST_SH, 32'h2000, 32'h1234, 32'd2, 6'd4, 32'd0, 2, 32'd0, 1'b0, 32'h2000, 4'b1100, 32'h1234_1234));
    tab.push_back(ls(LDST_SB, 32'h3000, 32'hAB, 32'd1, 6'd4, 32'd0, 1, 32'd0, 1'b0, 32'h3000, 4'b0010, 32'hABAB_ABAB));
    tab.push_back(ls(LDST_SW, 32'h3000, 32'hCAFE_F00D, 32'd8, 6'd4, 32'd0, 1, 32'd0, 1'b0, 32'h3008, 4'b1111, 32'hCAFE_F00D));
    tab.push_back(ls(LDST_SH, 32'h2000, 32'h1234, 32'd1, 6'd4, 32'd0, 0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0));
    tab.push_back(ls(LDST_LW, 32'h1002, 32'd0, 32'd0, 6'd7, 32'hFFFF_FFFF, 0, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0));
    repeat (3) @(negedge clock);
    chk("reset_pc", {pc, 1'b0}, 32'h8000_0000);
    chk("reset_pc_seq", 32'(pc_seq), 32'd0);
    chk("reset_complete", 32'(instr_complete), 32'd0);
    chk("reset_rd_wen", 32'(rd_wen), 32'd0);
    chk("reset_rd_wdata", rd_wdata, 32'd0);
    chk("reset_dvalid", 32'(dvalid), 32'd0);
    chk("reset_dwrite", 32'(dwrite), 32'd0);
    chk("reset_dstb_daddr", {dwstb, daddr[27:0]}, 32'd0);
    reset = 1'b0;
    m_pc = 32'h8000_0000;
    foreach (tab[i]) begin
      cur = i;
      issue(tab[i]);
    end
    @(negedge clock);
    cur = 100;
    chk("scoreboard_drained", sbq.size(), 0);
    op_type = OP_TYPE_ARITH; op = ALU_SLL; op_a = 32'd1; op_b = 32'd20; op_c = 32'd0; rd_waddr = 6'd9; instr_c = 1'b0;
    decode_valid = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    decode_valid = 1'b0;
    @(negedge clock);
    chk("rst_shift_complete", 32'(instr_complete), 32'd0);
    chk("rst_shift_rd_wen", 32'(rd_wen), 32'd0);
    chk("rst_shift_pc", {pc, 1'b0}, 32'h8000_0000);
    reset = 1'b0;
    n = 0;
    repeat (25) begin
      @(negedge clock);
      if (instr_complete) n++;
    end
    chk("rst_shift_no_retire", n, 0);
    cur = 101;
    op_type = OP_TYPE_LDST; op = LDST_LW; op_a = 32'h1000; op_b = 32'd0; op_c = 32'd0; rd_waddr = 6'd7;
    dready = 1'b0; decode_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 10 && n < 2; k++) begin
      @(negedge clock);
      if (dvalid) n++;
    end
    chk("mem_started", n, 2);
    reset = 1'b1;
    decode_valid = 1'b0;
    @(negedge clock);
    chk("rst_mem_dvalid", 32'(dvalid), 32'd0);
    chk("rst_mem_complete", 32'(instr_complete), 32'd0);
    chk("rst_mem_rd_wen", 32'(rd_wen), 32'd0);
    chk("rst_mem_pc", {pc, 1'b0}, 32'h8000_0000);
    reset = 1'b0;
    dready = 1'b1;
    n = 0;
    repeat (4) begin
      @(negedge clock);
      if (instr_complete || dvalid) n++;
    end
    dready = 1'b0;
    chk("rst_mem_quiet", n, 0);
    m_pc = 32'h8000_0000;
    cur = 102;
    issue(al(ALU_ADD, 32'd40, 32'd2, 6'd3, 1'b0, 32'd42, 2, 2'b00));
    @(negedge clock);
    chk("final_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwrisc_exec_stage.md
FWRISC_EXEC_STAGE -- requirements
Module: fwrisc_exec_stage

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- decode_valid  in  1  decoded instruction present; held until instr_complete
- instr_c  in  1  instruction is compressed (2-byte)
- op_type  in  5  ARITH, BRANCH, LDST, JUMP
- op_a, op_b  in  32  operands (rs1, rs2/imm)
- op  in  6  sub-op within op_type
- op_c  in  32  offset (branch/jump/load-store)
- rd_waddr  in  6  destination register; 0 = no write
- rd_wdata  out  32  writeback data
- rd_wen  out  1  writeback strobe, one cycle
- instr_complete  out  1  instruction retired, one cycle
- pc  out  31  current PC [31:1]
- pc_seq  out  1  last PC update was sequential
- daddr  out  32  data address, word-aligned
- dvalid  out  1  data request
- dwrite  out  1  request is a store
- dwdata  out  32  lane-replicated store data
- dwstb  out  4  byte strobes
- drdata  in  32  load data
- dready  in  1  data request accepted/completed

Function
REQ-002 FSM states SHALL be IDLE, EXEC, SHIFT, MEM; IDLE->EXEC on decode_valid.
REQ-003 EXEC SHALL retire ARITH (non-shift), BRANCH, JUMP in one cycle: instr_complete at the second clock edge after decode_valid is sampled, returning to IDLE.
REQ-004 ARITH ops SHALL be ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA; 32-bit wrap-around, no overflow flag.
REQ-005 Shifts SHALL go EXEC->SHIFT, shifting one bit per cycle for op_b[4:0] cycles; amount 0 retires from EXEC without entering SHIFT.
REQ-006 BRANCH ops EQ, NE, LT, GE, LTU, GEU: taken -> pc = pc + op_c; not taken -> pc += 2 (instr_c) else 4; no writeback.
REQ-007 JUMP SHALL write rd = pc + 2/4 and set pc = (op_a + op_c) with bit 0 cleared.
REQ-008 Non-taken/non-jump instructions SHALL advance pc by 2 (instr_c) or 4 at retirement.
REQ-009 pc_seq SHALL be 1 when the retiring update is pc+2/pc+4, else 0; held until next retirement.
REQ-010 LDST: EXEC->MEM; daddr = (op_a+op_c) & ~3; dvalid held until the cycle dready=1; retirement in the cycle after dready.
REQ-011 LDST op encoding: bit3 store, bit2 unsigned, bits1:0 size (0 byte, 1 half, 2 word).
REQ-012 Stores: dwstb from size and address[1:0]; dwdata = op_b replicated per lane; no writeback.
REQ-013 Loads: lane-extracted drdata, sign- or zero-extended, written to rd at retirement.
REQ-014 Misaligned half/word access SHALL complete with dvalid never asserted, no writeback, pc advancing normally.
REQ-015 rd_wen SHALL pulse with instr_complete only when rd_waddr != 0 and op writes a register.
REQ-016 decode_valid deasserting before retirement SHALL be ignored; the instruction completes.
REQ-017 dready outside MEM SHALL be ignored.

Reset
REQ-018 Reset SHALL force state IDLE, pc = 0x4000_0000 (byte address 0x8000_0000), pc_seq 0, all other outputs 0.
REQ-019 Reset mid-SHIFT or mid-MEM SHALL abort the instruction with no writeback and dvalid low next cycle.

Structure
REQ-020 Package fwrisc_exec_pkg SHALL hold op_type, ARITH, BRANCH and LDST op encodings, FSM state typedef and reset PC constant.
REQ-021 ALU (arith and compare) SHALL be sub-module fwrisc_alu, combinational.

Verification
REQ-022 Directed scenarios:
- ADD op_a=0xFFFF_FFFF op_b=1 rd=5 -> rd_wdata 0, rd_wen, complete 1 cycle after EXEC, pc +4, pc_seq 1.
- SRA op_a=0x8000_0000 op_b=4 -> 4 SHIFT cycles, rd_wdata 0xF800_0000; op_b=0 -> no SHIFT, result op_a.
- BEQ op_a=op_b=7 op_c=-8 at pc 0x8000_0010 -> pc 0x8000_0008, pc_seq 0, no rd_wen.
- LB unsigned=0 addr 0x1003, drdata 0x8000_0000, dready after 3 cycles -> daddr 0x1000, dvalid 3 cycles, rd_wdata 0xFFFF_FF80.
- SH op_b=0x1234 addr 0x2002 -> dwstb 0b1100, dwdata 0x1234_1234, dwrite 1; addr 0x2001 -> no dvalid.
- Reset asserted in MEM -> dvalid 0, no complete, pc 0x8000_0000.
